vdc_ramarb: RTL and testbench
=============================

// Module: vdc_ramarb
// PURPOSE
// - Slot scheduler for the VDC's single video-RAM port: one access per character column (newCol..endCol).
// - Shares each slot between three requesters: display fetch, DRAM refresh, and CPU/register-port access.
// - Sits between vdc_clockgen (timing pulses), the display fetch unit, the register-file CPU path and the VRAM.
// PARAMETERS
// - AW          16  VRAM address width
// - STARVE_MAX  4   pending CPU slots before the CPU outranks refresh (not display)
// PORTS
// - clk         in   1   clock
// - reset       in   1   synchronous, active-high
// - enable      in   1   pixel clock enable; nothing advances while low
// - newCol      in   1   slot start (from clockgen, qualified by enable)
// - newLine     in   1   scanline start; reloads the refresh budget
// - reg_drr     in   4   R36: refresh accesses per scanline (0 = none)
// - disp_req    in   1   display fetch wants this slot (sampled at slot start)
// - disp_addr   in   AW  display fetch address
// - disp_ack    out  1   1-clk pulse: display data valid
// - disp_data   out  8   display read data
// - cpu_req     in   1   level; held with cpu_we/addr/din until cpu_ack
// - cpu_we      in   1   1 = write
// - cpu_addr    in   AW  CPU address
// - cpu_din     in   8   CPU write data
// - cpu_ack     out  1   1-clk pulse: access complete; cpu_rdata valid for reads
// - cpu_rdata   out  8   CPU read data
// - cpu_busy    out  1   cpu_req seen and not yet acked (status-register ready = ~cpu_busy)
// - ram_en      out  1   access strobe, valid for one enable cycle
// - ram_we      out  1   write strobe (only with ram_en)
// - ram_addr    out  AW  RAM address
// - ram_din     out  8   RAM write data
// - ram_dout    in   8   RAM read data, valid on the enable cycle after ram_en
// BEHAVIOUR
// - Reset: every output is 0, the refresh budget is 0, rfsh_addr (8-bit) is 0, the starve counter is 0.
//   - Any in-flight access is dropped: no ack is issued and the requester must re-request.
// - All state changes only on clk edges with enable=1.
// - On enable&newLine the budget is loaded with reg_drr.
//   - If newLine and newCol coincide, the reload happens first, then the grant decision.
//   - A reg_drr change mid-line takes effect at the next newLine.
// - On enable&newCol, grant exactly one owner, in this priority:
//   1. display, if disp_req=1
//   2. CPU, if cpu_req=1 and starve=STARVE_MAX
//   3. refresh, if budget>0
//   4. CPU, if cpu_req=1
//   5. none (idle slot: ram_en=0)
// - Issue, registered at that edge:
//   - ram_en=1
//   - ram_addr=disp_addr | {0,rfsh_addr} | cpu_addr
//   - ram_we=cpu_we only for a CPU grant
//   - ram_din=cpu_din
//   - owner remembered
// - Refresh grant: budget-=1; rfsh_addr+=1, wrapping 255->0.
// - On the next enable edge: ram_en<=0, unless a new slot issues on that same edge (back-to-back slots when reg_cth=0).
// - Completion, on the enable edge after the issue cycle:
//   - display: disp_data<=ram_dout, disp_ack=1 for one clk
//   - CPU read: cpu_rdata<=ram_dout, cpu_ack=1
//   - CPU write: cpu_ack=1, data unchanged
//   - refresh: no ack
//   - Completion and the next issue may fall on the same edge; both take effect.
// - Latency: ack 2 enable cycles after the granting newCol edge.
// - cpu_busy: set when cpu_req=1 and no ack is pending; cleared with cpu_ack.
//   - The CPU is never granted twice for one request: no re-grant while its access is in flight.
// - Starve counter:
//   - +1 (saturating at STARVE_MAX) per slot where cpu_req=1 and the CPU is not granted.
//   - Cleared on a CPU grant or when cpu_req=0.
//   - Display always outranks the CPU, so starvation during visible fetch is by design.
// - cpu_req dropped before ack: any in-flight access still completes and acks; the CPU must ignore that ack.
// - enable low mid-access: state and outputs hold; ram_en stays high until the next enable edge.
// TESTING
// - reg_drr=5, no other requests, 10 slots after newLine -> slots 1-5 refresh at rfsh_addr 0..4, slots 6-10 idle.
// - disp_req every slot, cpu_req write 0x1234<=0xA5, drr=0 -> no CPU grant; cpu_busy stays 1 until disp_req drops, then ram_we at 0x1234, cpu_ack 2 enables after the grant.
// - cpu_req read with drr=15, STARVE_MAX=4 -> 4 refresh slots, then the CPU is granted in slot 5; cpu_rdata=RAM model value.
// - reg_cth=0 (newCol every enable), disp_req alternating addresses -> ram_en continuous, disp_ack every cycle, data in order.
// - rfsh_addr=255 then one refresh -> ram_addr=0x00FF and next rfsh_addr=0; newLine+newCol together with drr=1 -> refresh in that slot.
// - reset asserted the cycle after a CPU grant -> no cpu_ack, all outputs 0 next clk; re-request completes normally.

Source files
------------

// File: rtl/vdc_ramarb.sv
// Video-RAM slot arbiter: one access per character column, shared between display
// fetch, DRAM refresh and the CPU register port, with a two-stage completion pipeline.
module vdc_ramarb #(
    parameter int unsigned AW         = 16,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          newCol,
    input  logic          newLine,
    input  logic [3:0]    reg_drr,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_ack,
    output logic [7:0]    disp_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic          cpu_ack,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_busy,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    input  logic [7:0]    ram_dout
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_DISP,
        OWN_RFSH,
        OWN_CPU_RD,
        OWN_CPU_WR
    } owner_t;

    logic [3:0]    budget;
    logic [7:0]    rfsh_addr;
    logic [SW-1:0] starve;
    owner_t        s1_own;
    owner_t        s2_own;

    logic [3:0] budget_eff_c;
    logic       cpu_pend_c;
    logic       starved_c;
    logic       gnt_disp_c;
    logic       gnt_cpu_hi_c;
    logic       gnt_rfsh_c;
    logic       gnt_cpu_c;

    // Slot grant: a newLine reload is visible to a coincident newCol grant.
    always_comb begin
        budget_eff_c = newLine ? reg_drr : budget;
        cpu_pend_c   = (s1_own == OWN_CPU_RD) || (s1_own == OWN_CPU_WR) ||
                       (s2_own == OWN_CPU_RD) || (s2_own == OWN_CPU_WR);
        starved_c    = (starve == SW'(STARVE_MAX));
        gnt_disp_c   = newCol && disp_req;
        gnt_cpu_hi_c = newCol && !disp_req && cpu_req && !cpu_pend_c && starved_c;
        gnt_rfsh_c   = newCol && !disp_req && !gnt_cpu_hi_c && (budget_eff_c != 4'd0);
        gnt_cpu_c    = gnt_cpu_hi_c ||
                       (newCol && !disp_req && !gnt_rfsh_c && cpu_req && !cpu_pend_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            budget    <= 4'd0;
            rfsh_addr <= 8'd0;
            starve    <= SW'(0);
            s1_own    <= OWN_NONE;
            s2_own    <= OWN_NONE;
            disp_ack  <= 1'b0;
            disp_data <= 8'd0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= 8'd0;
            cpu_busy  <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= AW'(0);
            ram_din   <= 8'd0;
        end else begin
            disp_ack <= 1'b0;
            cpu_ack  <= 1'b0;
            if (enable) begin
                ram_en <= 1'b0;
                ram_we <= 1'b0;
                budget <= budget_eff_c;
                s2_own <= s1_own;
                s1_own <= OWN_NONE;

                // Issue stage
                if (gnt_disp_c) begin
                    ram_addr <= disp_addr;
                    s1_own   <= OWN_DISP;
                end else if (gnt_rfsh_c) begin
                    ram_addr  <= AW'(rfsh_addr);
                    rfsh_addr <= rfsh_addr + 8'd1;
                    budget    <= budget_eff_c - 4'd1;
                    s1_own    <= OWN_RFSH;
                end else if (gnt_cpu_c) begin
                    ram_addr <= cpu_addr;
                    ram_we   <= cpu_we;
                    s1_own   <= cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
                end
                if (gnt_disp_c || gnt_rfsh_c || gnt_cpu_c) begin
                    ram_en  <= 1'b1;
                    ram_din <= cpu_din;
                end

                // Completion stage: RAM data from the previous enable cycle
                case (s2_own)
                    OWN_DISP: begin
                        disp_data <= ram_dout;
                        disp_ack  <= 1'b1;
                    end
                    OWN_CPU_RD: begin
                        cpu_rdata <= ram_dout;
                        cpu_ack   <= 1'b1;
                    end
                    OWN_CPU_WR: cpu_ack <= 1'b1;
                    default: ;
                endcase

                if ((s2_own == OWN_CPU_RD) || (s2_own == OWN_CPU_WR)) begin
                    cpu_busy <= 1'b0;
                end else if (cpu_req && !cpu_pend_c) begin
                    cpu_busy <= 1'b1;
                end

                if (!cpu_req || gnt_cpu_c) begin
                    starve <= SW'(0);
                end else if (newCol && !starved_c) begin
                    starve <= starve + SW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vdc_ramarb.sv
// Directed bench for vdc_ramarb: refresh budget, priority/starvation, back-to-back
// slots, refresh address wrap, reset mid-access and enable stalls against a RAM model.
module tb_vdc_ramarb;

    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          newCol;
    logic          newLine;
    logic [3:0]    reg_drr;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_ack;
    logic [7:0]    disp_data;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_ack;
    logic [7:0]    cpu_rdata;
    logic          cpu_busy;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic [7:0]    ram_dout;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:65535];

    vdc_ramarb #(.AW(AW), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .newCol(newCol), .newLine(newLine),
        .reg_drr(reg_drr), .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_ack(disp_ack), .disp_data(disp_data), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cpu_busy(cpu_busy), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Synchronous VRAM model: read data valid the enable cycle after ram_en
    always @(posedge clk) begin
        if (enable && ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic slot();
        newCol = 1'b1;
        @(posedge clk);
        #1;
        newCol = 1'b0;
    endtask

    logic [15:0] addrs [0:7];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
        ram_dout  = 8'd0;
        reset     = 1'b1;
        enable    = 1'b1;
        newCol    = 1'b0;
        newLine   = 1'b0;
        reg_drr   = 4'd0;
        disp_req  = 1'b0;
        disp_addr = 16'h0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0;
        cpu_din   = 8'h0;
        idle();
        idle();

        // Reset state
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        chk("rst_disp_ack", 32'(disp_ack), 32'd0);
        chk("rst_disp_data", 32'(disp_data), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_cpu_busy", 32'(cpu_busy), 32'd0);
        reset = 1'b0;
        idle();

        // Refresh budget of 5: five refreshes at 0..4, then idle slots
        reg_drr = 4'd5;
        newLine = 1'b1;
        idle();
        newLine = 1'b0;
        for (int k = 0; k < 10; k++) begin
            slot();
            chk("rfsh_en", 32'(ram_en), (k < 5) ? 32'd1 : 32'd0);
            if (k < 5) chk("rfsh_addr", 32'(ram_addr), 32'(k));
            chk("rfsh_we", 32'(ram_we), 32'd0);
            idle();
            chk("rfsh_en_clr", 32'(ram_en), 32'd0);
        end

        // newLine+newCol with drr=1 refreshes in that slot; walk rfsh_addr through the wrap
        reg_drr = 4'd1;
        for (int i = 5; i <= 256; i++) begin
            newLine = 1'b1;
            slot();
            newLine = 1'b0;
            chk("wrap_en", 32'(ram_en), 32'd1);
            chk("wrap_addr", 32'(ram_addr), 32'(i % 256));
            idle();
        end
        reg_drr = 4'd0;
        newLine = 1'b1;
        idle();
        newLine = 1'b0;

        // Display owns every slot; the CPU write waits until display drops
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 16'h1234;
        cpu_din  = 8'hA5;
        disp_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            disp_addr = 16'h0300 + 16'(k * 17);
            slot();
            chk("disp_addr", 32'(ram_addr), 32'(16'h0300 + 16'(k * 17)));
            chk("disp_we", 32'(ram_we), 32'd0);
            chk("disp_busy", 32'(cpu_busy), 32'd1);
            if (k > 0) begin
                chk("disp_ack", 32'(disp_ack), 32'd1);
                chk("disp_data", 32'(disp_data), 32'(pat(16'h0300 + 16'((k - 1) * 17))));
            end
            idle();
            chk("disp_no_cpu_ack", 32'(cpu_ack), 32'd0);
        end
        disp_req = 1'b0;
        slot();
        chk("cpuw_en", 32'(ram_en), 32'd1);
        chk("cpuw_we", 32'(ram_we), 32'd1);
        chk("cpuw_addr", 32'(ram_addr), 32'h1234);
        chk("cpuw_din", 32'(ram_din), 32'hA5);
        chk("cpuw_last_disp_ack", 32'(disp_ack), 32'd1);
        idle();
        chk("cpuw_ack_early", 32'(cpu_ack), 32'd0);
        idle();
        chk("cpuw_ack", 32'(cpu_ack), 32'd1);
        chk("cpuw_busy_clr", 32'(cpu_busy), 32'd0);
        cpu_req = 1'b0;
        idle();
        chk("cpuw_ack_pulse", 32'(cpu_ack), 32'd0);

        // CPU read vs. refresh: four refresh slots, then starvation grants the CPU
        reg_drr  = 4'd15;
        newLine  = 1'b1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        idle();
        newLine = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            slot();
            chk("starve_rfsh_addr", 32'(ram_addr), 32'(k));
            chk("starve_rfsh_we", 32'(ram_we), 32'd0);
            idle();
        end
        slot();
        chk("cpur_en", 32'(ram_en), 32'd1);
        chk("cpur_addr", 32'(ram_addr), 32'h1234);
        chk("cpur_we", 32'(ram_we), 32'd0);
        idle();
        idle();
        chk("cpur_ack", 32'(cpu_ack), 32'd1);
        chk("cpur_rdata", 32'(cpu_rdata), 32'hA5);
        cpu_req = 1'b0;
        idle();

        // Back-to-back display slots (newCol every enable)
        for (int k = 0; k < 8; k++) addrs[k] = (k % 2 == 0) ? 16'h0100 + 16'(k) : 16'h8000 + 16'(k);
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                newCol    = 1'b1;
                disp_req  = 1'b1;
                disp_addr = addrs[k];
            end else begin
                newCol   = 1'b0;
                disp_req = 1'b0;
            end
            @(posedge clk);
            #1;
            if (k < 8) begin
                chk("b2b_en", 32'(ram_en), 32'd1);
                chk("b2b_addr", 32'(ram_addr), 32'(addrs[k]));
            end else begin
                chk("b2b_en_off", 32'(ram_en), 32'd0);
            end
            if (k >= 2) begin
                chk("b2b_ack", 32'(disp_ack), 32'd1);
                chk("b2b_data", 32'(disp_data), 32'(pat(addrs[k - 2])));
            end
        end
        idle();
        chk("b2b_ack_end", 32'(disp_ack), 32'd0);

        // Reset the cycle after a CPU grant drops the access
        reg_drr = 4'd0;
        newLine = 1'b1;
        idle();
        newLine  = 1'b0;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0042;
        slot();
        chk("rstg_en", 32'(ram_en), 32'd1);
        chk("rstg_addr", 32'(ram_addr), 32'h0042);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        chk("rstg_ram_en", 32'(ram_en), 32'd0);
        chk("rstg_ram_addr", 32'(ram_addr), 32'd0);
        chk("rstg_busy", 32'(cpu_busy), 32'd0);
        chk("rstg_ack", 32'(cpu_ack), 32'd0);
        idle();
        chk("rstg_no_ack", 32'(cpu_ack), 32'd0);
        chk("rstg_busy_again", 32'(cpu_busy), 32'd1);

        // Re-request with an enable stall mid-access
        slot();
        chk("rereq_en", 32'(ram_en), 32'd1);
        chk("rereq_addr", 32'(ram_addr), 32'h0042);
        enable = 1'b0;
        idle();
        idle();
        chk("stall_en_hold", 32'(ram_en), 32'd1);
        chk("stall_no_ack", 32'(cpu_ack), 32'd0);
        enable = 1'b1;
        idle();
        chk("stall_en_clr", 32'(ram_en), 32'd0);
        chk("stall_ack_early", 32'(cpu_ack), 32'd0);
        idle();
        chk("rereq_ack", 32'(cpu_ack), 32'd1);
        chk("rereq_rdata", 32'(cpu_rdata), 32'(pat(16'h0042)));
        cpu_req = 1'b0;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
